// File: rtl/reversi_pkg.sv
// Shared reversi definitions: cell codes, display colours and board geometry.
// The board engine and the renderer both import this package.
package reversi_pkg;

   localparam int BOARD_W   = 192;
   localparam int NUM_CELLS = 64;

   localparam logic [2:0] CELL_EMPTY  = 3'b000;
   localparam logic [2:0] CELL_ENABLE = 3'b100;
   localparam logic [2:0] CELL_WHITE  = 3'b110;
   localparam logic [2:0] CELL_BLACK  = 3'b111;

   localparam logic [2:0] COL_GRID   = 3'b001;
   localparam logic [2:0] COL_EMPTY  = 3'b010;
   localparam logic [2:0] COL_ENABLE = 3'b110;
   localparam logic [2:0] COL_WHITE  = 3'b111;
   localparam logic [2:0] COL_BLACK  = 3'b000;
   localparam logic [2:0] COL_ERR    = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_DONE = 2'd2
   } render_state_t;

endpackage

// File: rtl/reversi_cell_colour.sv
// Maps one cell code to its pixel colour.
// Grid pixels override the cell state.
module reversi_cell_colour
   import reversi_pkg::*;
(
   input  logic [2:0] code,
   input  logic       is_grid,
   output logic [2:0] colour
);

   always_comb begin
      colour = COL_ERR;
      if (is_grid) begin
         colour = COL_GRID;
      end else begin
         case (code)
            CELL_EMPTY:  colour = COL_EMPTY;
            CELL_ENABLE: colour = COL_ENABLE;
            CELL_WHITE:  colour = COL_WHITE;
            CELL_BLACK:  colour = COL_BLACK;
            default:     colour = COL_ERR;
         endcase
      end
   end

endmodule

// File: rtl/reversi_board_renderer.sv
// Rasters a snapshot of the 8x8 reversi board as one plot request per cycle
// for the 160x120 VGA adapter, then pulses done.
//
// state | meaning
// IDLE  | waiting for start; emits pixel 0 and snapshots board on start
// DRAW  | emitting pixels 1..N-1; counters wrap to zero after the last one
// DONE  | one-cycle done pulse, then back to IDLE
module reversi_board_renderer
   import reversi_pkg::*;
#(
   parameter int CELL = 12,
   parameter int X0   = 32,
   parameter int Y0   = 12
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic [BOARD_W-1:0] board,
   output logic [7:0]         x,
   output logic [6:0]         y,
   output logic [2:0]         colour,
   output logic               plot,
   output logic               busy,
   output logic               done
);

   localparam logic [3:0] LAST = 4'(CELL - 1);

   render_state_t      state, state_next;
   logic [BOARD_W-1:0] snap;
   logic [5:0]         idx, idx_next;
   logic [3:0]         lx, lx_next, ly, ly_next;
   logic               emit, load, frame_end, is_grid;
   logic [2:0]         code, pix_colour;
   logic [7:0]         px;
   logic [6:0]         py;

   // Counters are all-zero in IDLE (reset value, or wrapped after the last
   // pixel), so pixel 0 is emitted straight from IDLE. It is always a grid
   // pixel, so the not-yet-loaded snapshot never affects its colour.
   assign frame_end = (idx == 6'd0) && (lx == 4'd0) && (ly == 4'd0);
   assign is_grid   = (lx == 4'd0) || (ly == 4'd0);
   assign code      = snap[3*int'(idx) +: 3];

   // Low bits of the full-width sums; modular arithmetic keeps them exact.
   assign px = 8'(X0) + 8'(idx[2:0]) * 8'(CELL) + 8'(lx);
   assign py = 7'(Y0) + 7'(idx[5:3]) * 7'(CELL) + 7'(ly);

   reversi_cell_colour u_cell_colour (
      .code    (code),
      .is_grid (is_grid),
      .colour  (pix_colour)
   );

   always_comb begin
      state_next = state;
      emit       = 1'b0;
      load       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_DRAW;
               emit       = 1'b1;
               load       = 1'b1;
            end
         end
         ST_DRAW: begin
            if (frame_end) state_next = ST_DONE;
            else           emit       = 1'b1;
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      lx_next  = lx;
      ly_next  = ly;
      idx_next = idx;
      if (emit) begin
         if (lx == LAST) begin
            lx_next = 4'd0;
            if (ly == LAST) begin
               ly_next  = 4'd0;
               idx_next = idx + 6'd1;
            end else begin
               ly_next = ly + 4'd1;
            end
         end else begin
            lx_next = lx + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state  <= ST_IDLE;
         snap   <= '0;
         idx    <= '0;
         lx     <= '0;
         ly     <= '0;
         x      <= '0;
         y      <= '0;
         colour <= '0;
         plot   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
         lx    <= lx_next;
         ly    <= ly_next;
         if (load) snap <= board;
         plot <= emit;
         busy <= (state_next == ST_DRAW);
         done <= (state_next == ST_DONE);
         if (emit) begin
            x      <= px;
            y      <= py;
            colour <= pix_colour;
         end
      end
   end

endmodule

// File: tb/tb_reversi_board_renderer.sv
// Scoreboard bench for reversi_board_renderer: stimulus queues expected pixels,
// a negedge monitor pops and compares every plotted pixel and records frame timing.
module tb_reversi_board_renderer;

   localparam int N    = 9216;
   localparam int CELL = 12;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         start = 1'b0;
   logic [191:0] board = '0;
   logic [7:0]   x;
   logic [6:0]   y;
   logic [2:0]   colour;
   logic         plot, busy, done;

   reversi_board_renderer dut (
      .clk    (clk),
      .resetn (resetn),
      .start  (start),
      .board  (board),
      .x      (x),
      .y      (y),
      .colour (colour),
      .plot   (plot),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] px;
      logic [6:0] py;
      logic [2:0] pc;
   } pix_t;

   pix_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   frame_plots = 0;
   int   done_count = 0;
   int   first_cycs[$];
   int   done_cycs[$];
   int   frame_sizes[$];
   logic prev_plot = 1'b0;
   logic [7:0] first_x, last_x;
   logic [6:0] first_y, last_y;
   logic [2:0] first_c, last_c;
   logic [2:0] img [0:159][0:119];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [2:0] model_colour(input logic [2:0] code);
      case (code)
         3'b000:  return 3'b010;
         3'b100:  return 3'b110;
         3'b110:  return 3'b111;
         3'b111:  return 3'b000;
         default: return 3'b100;
      endcase
   endfunction

   function automatic logic [191:0] put(input logic [191:0] b, input int i, input logic [2:0] c);
      logic [191:0] r;
      r = b;
      r[3*i +: 3] = c;
      return r;
   endfunction

   task automatic push_frame(input logic [191:0] b);
      pix_t p;
      for (int i = 0; i < 64; i++)
         for (int ly = 0; ly < CELL; ly++)
            for (int lx = 0; lx < CELL; lx++) begin
               p.px = 8'(32 + (i % 8) * CELL + lx);
               p.py = 7'(12 + (i / 8) * CELL + ly);
               p.pc = (lx == 0 || ly == 0) ? 3'b001 : model_colour(b[3*i +: 3]);
               sb.push_back(p);
            end
   endtask

   // Monitor: samples outputs on the falling edge, away from the active edge.
   always @(negedge clk) begin
      pix_t p;
      check("busy_eq_plot", 32'(busy), 32'(plot));
      if (plot) begin
         if (sb.size() == 0) begin
            check("unexpected_plot", 32'(plot), 32'd0);
         end else begin
            p = sb.pop_front();
            check("pix_x", 32'(x), 32'(p.px));
            check("pix_y", 32'(y), 32'(p.py));
            check("pix_colour", 32'(colour), 32'(p.pc));
         end
         if (x < 8'd160 && y < 7'd120) img[x][y] = colour;
         if (!prev_plot) begin
            first_cycs.push_back(cyc);
            first_x = x;
            first_y = y;
            first_c = colour;
         end
         last_x = x;
         last_y = y;
         last_c = colour;
         frame_plots++;
      end
      if (done) begin
         check("done_without_plot", 32'(plot), 32'd0);
         done_cycs.push_back(cyc);
         frame_sizes.push_back(frame_plots);
         frame_plots = 0;
         done_count++;
      end
      prev_plot = plot;
   end

   task automatic clear_records();
      first_cycs.delete();
      done_cycs.delete();
      frame_sizes.delete();
      frame_plots = 0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int n;
      n = 0;
      while (done_count < target && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      if (done_count < target) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got %0d dones expected %0d", done_count, target);
      end
   endtask

   // Pulses start for one edge; returns the cycle in which pixel 0 is expected.
   task automatic pulse_start(output int ts);
      @(negedge clk); #1;
      start = 1'b1;
      ts = cyc + 1;
      @(negedge clk); #1;
      start = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_x"}, 32'(x), 32'd0);
      check({tag, "_y"}, 32'(y), 32'd0);
      check({tag, "_colour"}, 32'(colour), 32'd0);
      check({tag, "_plot"}, 32'(plot), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
   endtask

   initial begin
      logic [191:0] b1, b2, b3;
      int ts, dc, n;

      b1 = '0;
      b1 = put(b1, 27, 3'b110);
      b1 = put(b1, 28, 3'b111);
      b1 = put(b1, 35, 3'b111);
      b1 = put(b1, 36, 3'b110);
      b2 = put(b1, 0, 3'b100);
      b2 = put(b2, 63, 3'b101);
      b3 = put(b2, 9, 3'b010);
      b3 = put(b3, 18, 3'b100);

      // Reset and idle
      repeat (3) @(negedge clk);
      #1 resetn = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      check_outputs_zero("idle");
      check("idle_done_count", 32'(done_count), 32'd0);

      // Initial board frame
      clear_records();
      board = b1;
      push_frame(b1);
      pulse_start(ts);
      wait_done(1, N + 100);
      check("f1_first_cycle", 32'(first_cycs[0]), 32'(ts));
      check("f1_done_cycle", 32'(done_cycs[0]), 32'(ts + N));
      check("f1_plot_count", 32'(frame_sizes[0]), 32'(N));
      check("f1_first_x", 32'(first_x), 32'd32);
      check("f1_first_y", 32'(first_y), 32'd12);
      check("f1_first_colour", 32'(first_c), 32'b001);
      check("f1_33_13", 32'(img[33][13]), 32'b010);
      check("f1_69_49", 32'(img[69][49]), 32'b111);
      check("f1_81_49", 32'(img[81][49]), 32'b000);
      check("f1_sb_empty", 32'(sb.size()), 32'd0);

      // Legal-move cell 0 and error cell 63
      clear_records();
      board = b2;
      push_frame(b2);
      pulse_start(ts);
      wait_done(2, N + 100);
      check("f2_33_13", 32'(img[33][13]), 32'b110);
      check("f2_last_x", 32'(last_x), 32'd127);
      check("f2_last_y", 32'(last_y), 32'd107);
      check("f2_last_colour", 32'(last_c), 32'b100);
      check("f2_done_cycle", 32'(done_cycs[0]), 32'(ts + N));

      // Board toggling and stray start pulses during DRAW
      clear_records();
      board = b3;
      push_frame(b3);
      pulse_start(ts);
      n = 0;
      while (done_count < 3 && n < N + 100) begin
         board = ~board;
         start = (n % 7 == 3);
         @(negedge clk); #1;
         n++;
      end
      start = 1'b0;
      board = b3;
      if (done_count < 3) begin
         checks++;
         errors++;
         $display("FAIL toggle_timeout: got %0d dones expected 3", done_count);
      end
      repeat (30) @(negedge clk);
      #1;
      check("toggle_no_extra_frame", 32'(done_count), 32'd3);
      check("toggle_plot_count", 32'(frame_sizes[0]), 32'(N));
      check("toggle_sb_empty", 32'(sb.size()), 32'd0);

      // Reset in the middle of a frame
      clear_records();
      board = b1;
      push_frame(b1);
      pulse_start(ts);
      n = 0;
      while (frame_plots < 500 && n < 1000) begin
         @(negedge clk); #1;
         n++;
      end
      check("midreset_reached_500", 32'(frame_plots), 32'd500);
      resetn = 1'b0;
      start = 1'b1;
      sb.delete();
      @(negedge clk); #1;
      check_outputs_zero("midreset");
      start = 1'b0;
      resetn = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      check("midreset_no_done", 32'(done_count), 32'd3);
      clear_records();
      push_frame(b1);
      pulse_start(ts);
      wait_done(4, N + 100);
      check("restart_first_cycle", 32'(first_cycs[0]), 32'(ts));
      check("restart_first_x", 32'(first_x), 32'd32);
      check("restart_first_y", 32'(first_y), 32'd12);
      check("restart_plot_count", 32'(frame_sizes[0]), 32'(N));

      // start held high: three back-to-back frames
      clear_records();
      board = b2;
      push_frame(b2);
      push_frame(b2);
      push_frame(b2);
      @(negedge clk); #1;
      start = 1'b1;
      ts = cyc + 1;
      wait_done(7, 3 * N + 100);
      start = 1'b0;
      dc = done_count;
      repeat (30) @(negedge clk);
      #1;
      check("b2b_no_fourth_frame", 32'(done_count), 32'(dc));
      check("b2b_frames", 32'(frame_sizes.size()), 32'd3);
      check("b2b_first_cycle", 32'(first_cycs[0]), 32'(ts));
      for (int i = 0; i < 3 && i < frame_sizes.size(); i++) begin
         check("b2b_plot_count", 32'(frame_sizes[i]), 32'(N));
         check("b2b_done_cycle", 32'(done_cycs[i]), 32'(first_cycs[i] + N));
         if (i < 2 && i + 1 < first_cycs.size())
            check("b2b_idle_gap", 32'(first_cycs[i+1]), 32'(done_cycs[i] + 2));
      end
      check("b2b_sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
